// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction memory loader.
//               FSM state encoding, the RISC-V canonical NOP, and a helper
//               that locates the word-index field inside a byte address.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } imem_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Byte-offset bits below the word index of a fetch address.
    localparam int c_BYTE_OFS_W = 2;

    // MSB of the word-index field for a memory with an aw-bit word index.
    function automatic int widx_msb(input int aw);
        return aw + c_BYTE_OFS_W - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_decode
// Description : Combinational split of a byte fetch address into word index,
//               out-of-range and misalignment flags, and the overall
//               qualification of the fetch.
// Ports       : i_fetch_addr  - byte address from the core PC
//               i_prog_ready  - memory holds a complete program
//               o_widx        - word index into the memory array
//               o_oob         - address lies beyond the memory
//               o_misalign    - address is not word aligned
//               o_valid       - fetch returns a real program word
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_decode
    import imem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 8
) (
    input  logic [XLEN-1:0] i_fetch_addr,
    input  logic            i_prog_ready,
    output logic [AW-1:0]   o_widx,
    output logic            o_oob,
    output logic            o_misalign,
    output logic            o_valid
);

    localparam int c_WIDX_MSB = widx_msb(AW);

    assign o_widx     = i_fetch_addr[c_WIDX_MSB:c_BYTE_OFS_W];
    assign o_misalign = |i_fetch_addr[c_BYTE_OFS_W-1:0];

    // Any set bit above the word index addresses past the end of memory.
    generate
        if (c_WIDX_MSB + 1 < XLEN) begin : g_oob
            assign o_oob = |i_fetch_addr[XLEN-1:c_WIDX_MSB+1];
        end else begin : g_no_oob
            assign o_oob = 1'b0;
        end
    endgenerate

    assign o_valid = i_prog_ready & ~o_oob & ~o_misalign;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Parametrised instruction memory with a session-based
//               streaming loader and a byte-addressed combinational fetch
//               port. After reset the array is swept to zero, then programs
//               are streamed in with a valid/ready handshake of explicit
//               length. Fetches only return real words once a load is done.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               ld_start, ld_len  - open a load session of ld_len words
//               ld_valid, ld_data - load word stream
//               ld_ready          - loader accepts ld_data this cycle
//               ld_done           - memory holds a complete program
//               ld_err            - last ld_start carried an illegal length
//               busy              - clearing or loading
//               fetch_addr        - byte address from the core PC
//               fetch_inst        - instruction word (NOP when not valid)
//               fetch_valid       - fetch_inst is a real program word
//               fetch_misalign    - fetch_addr is not word aligned
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 256,
    parameter logic [XLEN-1:0]  NOP_WORD = XLEN'(RV_NOP),
    localparam int              AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_start,
    input  logic [AW:0]     ld_len,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    output logic            ld_done,
    output logic            ld_err,
    output logic            busy,
    input  logic [XLEN-1:0] fetch_addr,
    output logic [XLEN-1:0] fetch_inst,
    output logic            fetch_valid,
    output logic            fetch_misalign
);

    localparam logic [AW:0] c_DEPTH_W    = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_LAST_IDX   = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] c_ONE        = (AW+1)'(1);

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    imem_state_t     r_state;
    imem_state_t     w_state_nxt;
    logic [AW:0]     r_cnt;
    logic [AW:0]     w_cnt_nxt;
    logic [AW:0]     r_len;
    logic [AW:0]     w_len_nxt;
    logic            r_ld_ready;
    logic            w_ld_ready_nxt;
    logic            r_ld_done;
    logic            w_ld_done_nxt;
    logic            r_ld_err;
    logic            w_ld_err_nxt;
    logic            r_busy;
    logic            w_busy_nxt;

    logic            w_mem_we;
    logic [XLEN-1:0] w_mem_wdata;
    logic [XLEN-1:0] r_mem [DEPTH];

    logic            w_len_legal;
    logic            w_accept;

    assign w_len_legal = (ld_len != '0) && (ld_len <= c_DEPTH_W);
    // ld_ready is only ever high in LOAD, so it alone qualifies the accept.
    assign w_accept    = ld_valid && r_ld_ready;

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_len_nxt      = r_len;
        w_ld_ready_nxt = r_ld_ready;
        w_ld_done_nxt  = r_ld_done;
        w_ld_err_nxt   = r_ld_err;
        w_busy_nxt     = r_busy;
        w_mem_we       = 1'b0;
        w_mem_wdata    = '0;

        case (r_state)
            ST_CLEAR: begin
                w_mem_we  = 1'b1;
                w_cnt_nxt = r_cnt + c_ONE;
                if (r_cnt == c_LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end

            ST_IDLE, ST_DONE: begin
                if (ld_start) begin
                    if (w_len_legal) begin
                        w_state_nxt    = ST_LOAD;
                        w_len_nxt      = ld_len;
                        w_cnt_nxt      = '0;
                        w_ld_err_nxt   = 1'b0;
                        w_ld_done_nxt  = 1'b0;
                        w_ld_ready_nxt = 1'b1;
                        w_busy_nxt     = 1'b1;
                    end else begin
                        // Rejected request: stay put, keep any finished program.
                        w_ld_err_nxt = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (w_accept) begin
                    w_mem_we    = 1'b1;
                    w_mem_wdata = ld_data;
                    w_cnt_nxt   = r_cnt + c_ONE;
                    if (r_cnt == r_len - c_ONE) begin
                        w_state_nxt    = ST_DONE;
                        w_ld_done_nxt  = 1'b1;
                        w_ld_ready_nxt = 1'b0;
                        w_busy_nxt     = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_cnt      <= '0;
            r_len      <= '0;
            r_ld_ready <= 1'b0;
            r_ld_done  <= 1'b0;
            r_ld_err   <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_ld_ready <= w_ld_ready_nxt;
            r_ld_done  <= w_ld_done_nxt;
            r_ld_err   <= w_ld_err_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // The array itself has no reset; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[r_cnt[AW-1:0]] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Fetch port
    // ------------------------------------------------------------------
    logic [AW-1:0] w_fetch_widx;
    logic          w_fetch_oob;
    logic          w_fetch_misalign;
    logic          w_fetch_valid;

    imem_fetch_decode #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_fetch_decode (
        .i_fetch_addr (fetch_addr),
        .i_prog_ready (r_state == ST_DONE),
        .o_widx       (w_fetch_widx),
        .o_oob        (w_fetch_oob),
        .o_misalign   (w_fetch_misalign),
        .o_valid      (w_fetch_valid)
    );

    // oob is already folded into valid; repeating it here keeps the array
    // read explicitly guarded by the range check.
    assign fetch_inst     = (w_fetch_valid && !w_fetch_oob) ? r_mem[w_fetch_widx] : NOP_WORD;
    assign fetch_valid    = w_fetch_valid;
    assign fetch_misalign = w_fetch_misalign;

    assign ld_ready = r_ld_ready;
    assign ld_done  = r_ld_done;
    assign ld_err   = r_ld_err;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (DEPTH=16). A
//               behavioural model tracks sweep time remaining, the open load
//               session and the program image; a negedge process compares
//               every output against it. Directed checks pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ld_start = 1'b0;
    logic [AW:0]     ld_len = '0;
    logic            ld_valid = 1'b0;
    logic [XLEN-1:0] ld_data = '0;
    logic            ld_ready;
    logic            ld_done;
    logic            ld_err;
    logic            busy;
    logic [XLEN-1:0] fetch_addr = '0;
    logic [XLEN-1:0] fetch_inst;
    logic            fetch_valid;
    logic            fetch_misalign;

    imem_loader #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ld_start       (ld_start),
        .ld_len         (ld_len),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .ld_done        (ld_done),
        .ld_err         (ld_err),
        .busy           (busy),
        .fetch_addr     (fetch_addr),
        .fetch_inst     (fetch_inst),
        .fetch_valid    (fetch_valid),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit          m_known = 0;
    int          m_clear_left = 0;   // cycles of zero sweep still to run
    bit          m_loading = 0;
    int          m_pos = 0;
    int          m_len = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    logic [31:0] m_mem [DEPTH];

    always @(posedge clk) begin
        if (rst) begin
            m_known      = 1;
            m_clear_left = DEPTH;
            m_loading    = 0;
            m_done       = 0;
            m_err        = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        end else if (m_known) begin
            if (m_clear_left > 0) begin
                m_clear_left--;
            end else if (m_loading) begin
                if (ld_valid) begin
                    m_mem[m_pos] = ld_data;
                    m_pos++;
                    if (m_pos == m_len) begin
                        m_loading = 0;
                        m_done    = 1;
                    end
                end
            end else if (ld_start) begin
                if (int'(ld_len) >= 1 && int'(ld_len) <= DEPTH) begin
                    m_len     = int'(ld_len);
                    m_pos     = 0;
                    m_err     = 0;
                    m_done    = 0;
                    m_loading = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        if (m_done && a[1:0] == 2'b00 && a < 32'(DEPTH * 4))
            return m_mem[int'(a >> 2)];
        return 32'h0000_0013;
    endfunction

    function automatic logic exp_valid(input logic [31:0] a);
        return m_done && a[1:0] == 2'b00 && a < 32'(DEPTH * 4);
    endfunction

    always @(negedge clk) begin
        if (m_known) begin
            chk("busy",           {31'b0, busy},           {31'b0, (m_clear_left > 0) || m_loading});
            chk("ld_ready",       {31'b0, ld_ready},       {31'b0, m_loading});
            chk("ld_done",        {31'b0, ld_done},        {31'b0, m_done});
            chk("ld_err",         {31'b0, ld_err},         {31'b0, m_err});
            chk("fetch_inst",     fetch_inst,              exp_inst(fetch_addr));
            chk("fetch_valid",    {31'b0, fetch_valid},    {31'b0, exp_valid(fetch_addr)});
            chk("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, fetch_addr[1:0] != 2'b00});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit          rand_fetch = 0;
    logic [31:0] wq[$];   // forced load data, else random
    int          gq[$];   // forced idle gaps before each word, else random

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0, 1:    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            2:       a = 32'($urandom_range(0, DEPTH * 4 - 1));
            default: a = $urandom;
        endcase
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_fetch) fetch_addr = rand_addr();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Waits out the sweep, poking ld_start (which must be ignored).
    task automatic wait_clear(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            ld_start = 1'($urandom_range(0, 1));
            ld_len   = 5'd3;
            n++;
            tick();
        end
        ld_start = 1'b0;
        if (n >= 64) begin
            vectors++;
            miscompares++;
            $display("FAIL clear_timeout: busy still %b after %0d cycles", busy, n);
        end
    endtask

    task automatic do_load(input int len, input int max_gap, input bit noisy);
        int gap;
        ld_start = 1'b1;
        ld_len   = 5'(len);
        tick();
        ld_start = 1'b0;
        for (int w = 0; w < len; w++) begin
            gap = (gq.size() > 0) ? gq.pop_front() : int'($urandom_range(0, max_gap));
            for (int g = 0; g < gap; g++) begin
                ld_valid = 1'b0;
                ld_data  = $urandom;
                if (noisy) begin
                    ld_start = 1'($urandom_range(0, 1));
                    ld_len   = 5'($urandom_range(0, 31));
                end
                tick();
            end
            ld_start = 1'b0;
            ld_valid = 1'b1;
            ld_data  = (wq.size() > 0) ? wq.pop_front() : $urandom;
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] a,
                             input logic [31:0] inst, input logic vld);
        fetch_addr = a;
        #1;
        chk({name, "_inst"},  fetch_inst,         inst);
        chk({name, "_valid"}, {31'b0, fetch_valid}, {31'b0, vld});
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;

        // Reset sweep: busy for exactly DEPTH cycles.
        do_reset();
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        chk("clear_busy_cycles", 32'(n), 32'd16);
        chk("post_clear_done", {31'b0, ld_done}, 32'd0);
        fetch_chk("post_clear", 32'h0, 32'h0000_0013, 1'b0);

        // Three words, back to back.
        wq = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        gq = '{0, 0, 0};
        do_load(3, 0, 0);
        chk("load3_done", {31'b0, ld_done}, 32'd1);
        fetch_chk("load3_w0", 32'h0, 32'h0050_0093, 1'b1);
        fetch_chk("load3_w1", 32'h4, 32'h00A0_0113, 1'b1);
        fetch_chk("load3_w2", 32'h8, 32'h0020_81B3, 1'b1);
        fetch_chk("load3_w3", 32'hC, 32'h0000_0000, 1'b1);

        // Throttled reload: ld_valid 1,0,0,1; word 2 keeps its old value.
        wq = '{32'h1111_1111, 32'h2222_2222};
        gq = '{0, 2};
        do_load(2, 0, 0);
        fetch_chk("thr_w0", 32'h0, 32'h1111_1111, 1'b1);
        fetch_chk("thr_w1", 32'h4, 32'h2222_2222, 1'b1);
        fetch_chk("thr_w2", 32'h8, 32'h0020_81B3, 1'b1);

        // Fetch qualification.
        fetch_chk("misalign", 32'h6, 32'h0000_0013, 1'b0);
        chk("misalign_flag", {31'b0, fetch_misalign}, 32'd1);
        fetch_chk("oob", 32'(DEPTH * 4), 32'h0000_0013, 1'b0);

        // Illegal lengths from IDLE.
        do_reset();
        wait_clear(n);
        ld_start = 1'b1;
        ld_len   = 5'd0;
        tick();
        ld_start = 1'b0;
        chk("len0_err", {31'b0, ld_err}, 32'd1);
        chk("len0_busy", {31'b0, busy}, 32'd0);
        ld_start = 1'b1;
        ld_len   = 5'(DEPTH + 1);
        tick();
        ld_start = 1'b0;
        chk("len17_err", {31'b0, ld_err}, 32'd1);
        chk("len17_busy", {31'b0, busy}, 32'd0);
        chk("len17_ready", {31'b0, ld_ready}, 32'd0);
        wq = '{32'hCAFE_0001};
        gq = '{0};
        do_load(1, 0, 0);
        chk("legal_clears_err", {31'b0, ld_err}, 32'd0);

        // Reset in the middle of an 8-word load.
        ld_start = 1'b1;
        ld_len   = 5'd8;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hA5A5_0000 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        do_reset();
        wait_clear(n);
        chk("midload_done", {31'b0, ld_done}, 32'd0);
        wq = '{32'hDEAD_BEEF};
        gq = '{1};
        do_load(1, 0, 0);
        chk("midload_new_done", {31'b0, ld_done}, 32'd1);
        fetch_chk("midload_w0", 32'h0, 32'hDEAD_BEEF, 1'b1);
        fetch_chk("midload_w1", 32'h4, 32'h0, 1'b1);
        fetch_chk("midload_w2", 32'h8, 32'h0, 1'b1);
        fetch_chk("midload_w3", 32'hC, 32'h0, 1'b1);

        // Randomized sessions checked by the model every cycle.
        rand_fetch = 1;
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 19))
                0: begin
                    do_reset();
                    wait_clear(n);
                end
                1: begin
                    ld_start = 1'b1;
                    ld_len   = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(DEPTH + 1, 31));
                    tick();
                    ld_start = 1'b0;
                end
                2: begin
                    // Reset partway through a session.
                    ld_start = 1'b1;
                    ld_len   = 5'($urandom_range(2, DEPTH));
                    tick();
                    ld_start = 1'b0;
                    ld_valid = 1'b1;
                    ld_data  = $urandom;
                    tick();
                    ld_valid = 1'b0;
                    do_reset();
                    wait_clear(n);
                end
                default: do_load(int'($urandom_range(1, DEPTH)), 3, 1);
            endcase
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
        end
        rand_fetch = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1);
    end

endmodule
`default_nettype wire
